// File: rtl/noc_flit_pkg.sv
// Shared flit layout constants and packetizer state type.
// Defaults match the fabric port configuration used by noc_writer.
package noc_flit_pkg;

    localparam int DEF_WIDTH            = 36;
    localparam int DEF_N                = 16;
    localparam int DEF_NUM_VC           = 2;
    localparam int DEF_MAX_FLITS        = 4;
    localparam int DEF_ASSIGNED_VC      = 0;

    localparam int DEF_ADDRESS_WIDTH    = $clog2(DEF_N);
    localparam int DEF_VC_ADDRESS_WIDTH = $clog2(DEF_NUM_VC);

    localparam int DATA_WIDTH = DEF_WIDTH - 3 - DEF_VC_ADDRESS_WIDTH
                              - DEF_ADDRESS_WIDTH;

    localparam int VALID_POS  = DEF_WIDTH - 1;
    localparam int HEAD_POS   = DEF_WIDTH - 2;
    localparam int TAIL_POS   = DEF_WIDTH - 3;
    localparam int VC_POS     = DEF_WIDTH - 4;
    localparam int DEST_POS   = DEF_WIDTH - 4 - DEF_VC_ADDRESS_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/flit_formatter.sv
// Packs head/tail/vc/dest/data into one flit; the valid bit is always set.
// Purely combinational so depacketizer checks can reuse the same layout.
module flit_formatter #(
    parameter  int WIDTH            = 36,
    parameter  int VC_ADDRESS_WIDTH = 1,
    parameter  int ADDRESS_WIDTH    = 4,
    localparam int DATA_WIDTH       = WIDTH - 3 - VC_ADDRESS_WIDTH
                                    - ADDRESS_WIDTH
) (
    input  logic                        i_head,
    input  logic                        i_tail,
    input  logic [VC_ADDRESS_WIDTH-1:0] i_vc,
    input  logic [ADDRESS_WIDTH-1:0]    i_dest,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]            o_flit
);

    assign o_flit = {1'b1, i_head, i_tail, i_vc, i_dest, i_data};

endmodule

// File: rtl/noc_packetizer.sv
// Splits one accepted multi-flit packet into stamped NoC flits and
// writes them in order into the afifo, stalling while it is full.
module noc_packetizer
    import noc_flit_pkg::*;
#(
    parameter  int WIDTH            = DEF_WIDTH,
    parameter  int N                = DEF_N,
    parameter  int NUM_VC           = DEF_NUM_VC,
    parameter  int MAX_FLITS        = DEF_MAX_FLITS,
    parameter  int ASSIGNED_VC      = DEF_ASSIGNED_VC,
    localparam int ADDRESS_WIDTH    = $clog2(N),
    localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
    localparam int LEN_WIDTH        = $clog2(MAX_FLITS) + 1,
    localparam int DWIDTH           = WIDTH - 3 - VC_ADDRESS_WIDTH
                                    - ADDRESS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_FLITS*DWIDTH-1:0] i_packet_in,
    input  logic [ADDRESS_WIDTH-1:0]    i_dest_in,
    input  logic [LEN_WIDTH-1:0]        i_length_in,
    input  logic                        i_valid_in,
    output logic                        o_ready_out,
    output logic [WIDTH-1:0]            o_flit_out,
    output logic                        o_write_en,
    input  logic                        i_full_in
);

    localparam logic [VC_ADDRESS_WIDTH-1:0] VC_VAL =
        VC_ADDRESS_WIDTH'(ASSIGNED_VC);

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic [MAX_FLITS*DWIDTH-1:0]   r_payload;
    logic [ADDRESS_WIDTH-1:0]      r_dest;
    logic [LEN_WIDTH-1:0]          r_len;
    logic [LEN_WIDTH-1:0]          r_idx;

    logic [LEN_WIDTH-1:0]          w_len_norm;
    logic [DWIDTH-1:0]             w_data;
    logic [WIDTH-1:0]              w_flit;
    logic                          w_head;
    logic                          w_tail;
    logic                          w_write;
    logic                          w_ready;
    logic                          w_accept;

    assign w_head   = (r_idx == '0);
    assign w_tail   = (r_idx == r_len - LEN_WIDTH'(1));
    assign w_accept = i_valid_in & w_ready;

    always_comb begin
        w_len_norm = i_length_in;
        if (i_length_in == '0) begin
            w_len_norm = LEN_WIDTH'(1);
        end else if (i_length_in > LEN_WIDTH'(MAX_FLITS)) begin
            w_len_norm = LEN_WIDTH'(MAX_FLITS);
        end
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < MAX_FLITS; k++) begin
            if (r_idx == LEN_WIDTH'(k)) begin
                w_data = r_payload[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // A tail write frees the slot, so a waiting packet is taken on the
    // same edge and SEND continues without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_ready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (i_valid_in) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_write = ~i_full_in;
                w_ready = w_tail & ~i_full_in;
                if (w_write && w_tail && !i_valid_in) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_payload <= '0;
            r_dest    <= '0;
            r_len     <= LEN_WIDTH'(1);
            r_idx     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_payload <= i_packet_in;
                r_dest    <= i_dest_in;
                r_len     <= w_len_norm;
                r_idx     <= '0;
            end else if (w_write && !w_tail) begin
                r_idx <= r_idx + LEN_WIDTH'(1);
            end
        end
    end

    flit_formatter #(
        .WIDTH            (WIDTH),
        .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
        .ADDRESS_WIDTH    (ADDRESS_WIDTH)
    ) u_fmt (
        .i_head (w_head),
        .i_tail (w_tail),
        .i_vc   (VC_VAL),
        .i_dest (r_dest),
        .i_data (w_data),
        .o_flit (w_flit)
    );

    assign o_flit_out  = (r_state == SEND) ? w_flit : '0;
    assign o_write_en  = w_write;
    assign o_ready_out = w_ready;

endmodule
